// File: rtl/day7_pkg.sv
// Shared constants, ASCII codes and emit-state encoding for the day-7 row packer.
// Optional start-column checking in the top is enabled by DAY7_START_CHECK_EN.
package day7_pkg;

  localparam int WIDTH  = 141;
  localparam int HEIGHT = 142;
  localparam int WORDS  = (WIDTH + 31) / 32;
  localparam int MIDDLE = WIDTH / 2;

  localparam logic [7:0] CH_SPLIT = 8'h5e;
  localparam logic [7:0] CH_EMPTY = 8'h2e;
  localparam logic [7:0] CH_START = 8'h53;
  localparam logic [7:0] CH_LF    = 8'h0a;
  localparam logic [7:0] CH_CR    = 8'h0d;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FLUSH = 2'd2
  } emit_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/day7_row_emitter.sv
// Emit buffer and word sequencer: streams one loaded row as WORDS 32-bit words
// over a valid/ready handshake and signals done once the final row has drained.
module day7_row_emitter #(
  parameter int WORDS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WORDS*32-1:0]   load_data,
  input  logic                  flush,
  input  logic                  ready_in,
  output logic [31:0]           data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  row_sent,
  output logic                  done
);
  import day7_pkg::*;

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  emit_state_e                 state_r;
  logic [WORDS-1:0][31:0]      buf_r;
  logic [IW-1:0]               idx_r;
  logic [IW-1:0]               idx_next_s;
  logic                        full_r;
  logic                        valid_r;
  logic                        done_r;
  logic [31:0]                 data_r;
  logic                        hs_s;
  logic                        last_hs_s;

  // handshake decode; row_sent is combinational so a waiting row can load on the same edge
  always_comb begin
    hs_s       = valid_r & ready_in;
    last_hs_s  = hs_s & (idx_r == LAST_IDX);
    idx_next_s = idx_r + IW'(1);
  end

  // emit FSM: load, per-word stepping, end-of-file drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      buf_r   <= '0;
      idx_r   <= '0;
      full_r  <= 1'b0;
      valid_r <= 1'b0;
      data_r  <= 32'h0000_0000;
      done_r  <= 1'b0;
    end else begin
      if (load) begin
        buf_r   <= load_data;
        full_r  <= 1'b1;
        idx_r   <= '0;
        valid_r <= 1'b1;
        data_r  <= load_data[31:0];
        state_r <= flush ? FLUSH : SEND;
      end else if (last_hs_s) begin
        full_r  <= 1'b0;
        valid_r <= 1'b0;
        data_r  <= 32'h0000_0000;
        idx_r   <= '0;
        if (flush || state_r == FLUSH) begin
          state_r <= FLUSH;
          done_r  <= 1'b1;
        end else begin
          state_r <= IDLE;
        end
      end else begin
        if (hs_s) begin
          idx_r  <= idx_next_s;
          data_r <= buf_r[idx_next_s];
        end
        if (flush || state_r == FLUSH) begin
          state_r <= FLUSH;
          if (!full_r) begin
            done_r <= 1'b1;
          end
        end
      end
    end
  end

  assign data_out  = data_r;
  assign valid_out = valid_r;
  assign full      = full_r;
  assign row_sent  = last_hs_s;
  assign done      = done_r;

endmodule

// File: rtl/day7_row_packer.sv
// Turns the day-7 ASCII grid into 141-bit splitter bitmaps, five words per row.
// Define DAY7_START_CHECK_EN to validate the 'S' start marker and expose start_col.
module day7_row_packer #(
  parameter int WIDTH  = 141,
  parameter int HEIGHT = 142
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic        char_last,
  output logic [31:0] data_out,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [7:0]  rows_out,
  output logic        done,
  output logic        error
`ifdef DAY7_START_CHECK_EN
  ,
  output logic [7:0]  start_col
`endif
);
  import day7_pkg::*;

  localparam int WORDS = (WIDTH + 31) / 32;
  localparam int CW    = $clog2(WIDTH + 1);

  logic                  en_r;
  logic                  flush_r;
  logic                  error_r;
  logic [7:0]            rows_r;
  logic [WIDTH-1:0]      coll_r;
  logic [WIDTH-1:0]      coll_next_s;
  logic [CW-1:0]         col_r;
  logic [CW-1:0]         col_next_s;
  logic                  is_split_s;
  logic                  is_start_s;
  logic                  is_empty_s;
  logic                  is_lf_s;
  logic                  is_cr_s;
  logic                  is_map_s;
  logic                  row_end_s;
  logic                  char_ready_s;
  logic                  xfer_s;
  logic                  overflow_s;
  logic                  load_s;
  logic                  short_s;
  logic                  bad_s;
  logic                  flush_s;
  logic                  start_err_s;
  logic [WORDS*32-1:0]   row_words_s;
  logic                  emit_full_s;
  logic                  row_sent_s;
  logic                  emit_done_s;

  // byte decode and input flow control; a row end stalls only while the emit buffer stays busy
  always_comb begin
    is_split_s   = (char_in == CH_SPLIT);
    is_start_s   = (char_in == CH_START);
    is_empty_s   = (char_in == CH_EMPTY) | is_start_s;
    is_lf_s      = (char_in == CH_LF);
    is_cr_s      = (char_in == CH_CR);
    is_map_s     = is_split_s | is_empty_s;
    row_end_s    = char_valid & (is_lf_s | char_last);
    char_ready_s = en_r & ~flush_r & ~(row_end_s & emit_full_s & ~row_sent_s);
    xfer_s       = char_valid & char_ready_s;
    flush_s      = flush_r | (xfer_s & char_last);
  end

  // next collect-buffer image including the current byte, so char_last can close the row
  always_comb begin
    coll_next_s = coll_r;
    col_next_s  = col_r;
    overflow_s  = 1'b0;
    if (is_map_s) begin
      if (col_r < CW'(WIDTH)) begin
        coll_next_s[col_r] = is_split_s;
        col_next_s         = col_r + CW'(1);
      end else begin
        overflow_s = 1'b1;
      end
    end else begin
      col_next_s = col_r;
    end
    load_s      = xfer_s & row_end_s & (col_next_s != '0);
    short_s     = load_s & (col_next_s < CW'(WIDTH));
    bad_s       = xfer_s & ~(is_map_s | is_lf_s | is_cr_s);
    row_words_s = '0;
    row_words_s[WIDTH-1:0] = coll_next_s;
  end

  // collect state, row counter and sticky status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_r    <= 1'b0;
      flush_r <= 1'b0;
      coll_r  <= '0;
      col_r   <= '0;
      rows_r  <= 8'd0;
      error_r <= 1'b0;
    end else begin
      en_r <= 1'b1;
      if (xfer_s & char_last) begin
        flush_r <= 1'b1;
      end
      if (xfer_s) begin
        if (row_end_s) begin
          coll_r <= '0;
          col_r  <= '0;
        end else begin
          coll_r <= coll_next_s;
          col_r  <= col_next_s;
        end
      end
      if (row_sent_s) begin
        rows_r <= sat_inc8(rows_r);
      end
      if (bad_s | (xfer_s & overflow_s) | short_s | start_err_s |
          (emit_done_s & (rows_r != 8'(HEIGHT)))) begin
        error_r <= 1'b1;
      end
    end
  end

`ifdef DAY7_START_CHECK_EN
  localparam int MIDDLE_COL = WIDTH / 2;

  logic [7:0] start_col_r;
  logic [7:0] row_idx_r;
  logic [1:0] s_cnt_r;
  logic [1:0] s_total_s;
  logic       s_here_s;

  // start marker must appear once, in row 0, at the middle column
  always_comb begin
    s_here_s  = xfer_s & is_start_s & ~overflow_s;
    s_total_s = s_cnt_r + {1'b0, s_here_s};
    if (s_here_s & ((row_idx_r != 8'd0) | (col_r != CW'(MIDDLE_COL)))) begin
      start_err_s = 1'b1;
    end else if (load_s & (row_idx_r == 8'd0) & (s_total_s != 2'd1)) begin
      start_err_s = 1'b1;
    end else begin
      start_err_s = 1'b0;
    end
  end

  // start-marker tracking state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_col_r <= 8'd0;
      row_idx_r   <= 8'd0;
      s_cnt_r     <= 2'd0;
    end else begin
      if (s_here_s) begin
        start_col_r <= 8'(col_r);
      end
      if (xfer_s & row_end_s) begin
        s_cnt_r <= 2'd0;
      end else if (s_here_s && s_cnt_r != 2'd2) begin
        s_cnt_r <= s_cnt_r + 2'd1;
      end
      if (load_s) begin
        row_idx_r <= sat_inc8(row_idx_r);
      end
    end
  end

  assign start_col = start_col_r;
`else
  assign start_err_s = 1'b0;
`endif

  day7_row_emitter #(
    .WORDS(WORDS)
  ) u_emitter (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_data (row_words_s),
    .flush     (flush_s),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .full      (emit_full_s),
    .row_sent  (row_sent_s),
    .done      (emit_done_s)
  );

  assign char_ready = char_ready_s;
  assign rows_out   = rows_r;
  assign done       = emit_done_s;
  assign error      = error_r;

endmodule

// File: tb/tb_day7_row_packer.sv
// Directed bench for day7_row_packer: table-driven rows plus multi-cycle backpressure,
// error, full-file and reset sequences.
module tb_day7_row_packer;

  logic        clk;
  logic        rst;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        char_last;
  logic [31:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic [7:0]  rows_out;
  logic        done;
  logic        error;

  day7_row_packer dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_last  (char_last),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .rows_out   (rows_out),
    .done       (done),
    .error      (error)
  );

  typedef struct {
    string            name;
    logic [140:0]     bm;
    logic             s;
    logic [4:0][31:0] w;
  } vec_t;

  vec_t        vt[5];
  int          checks;
  int          failures;
  logic [31:0] got[0:2047];
  int          gcyc[0:2047];
  int          wr_cnt;
  int          rd_ptr;
  int          mcyc;
  int          done_cyc;
  logic        done_seen;
  logic        tog_run;
  logic [31:0] expw[0:709];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0][31:0] mk(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3,
                                          input logic [31:0] w4);
    return {w4, w3, w2, w1, w0};
  endfunction

  function automatic logic [140:0] row_bm(input int r);
    logic [140:0] b;
    b = '0;
    if (r != 0) begin
      for (int c = 0; c < 141; c++) begin
        if (((c * 7 + r * 3) % 13) == 0) b[c] = 1'b1;
      end
    end
    return b;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    char_in = b; char_valid = 1'b1; char_last = last;
    @(negedge clk);
    while (!char_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (!char_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: got char_ready=0 expected 1 for byte %h", b);
    end
    @(posedge clk); #1;
    char_valid = 1'b0; char_last = 1'b0;
  endtask

  task automatic send_cols(input logic [140:0] bm, input int ncols, input logic s_mid);
    logic [7:0] ch;
    for (int c = 0; c < ncols; c++) begin
      if (c >= 141) ch = 8'h5e;
      else if (bm[c]) ch = 8'h5e;
      else if (s_mid && c == 70) ch = 8'h53;
      else ch = 8'h2e;
      send_byte(ch, 1'b0);
    end
  endtask

  task automatic send_row(input logic [140:0] bm, input int ncols, input logic s_mid, input logic last);
    send_cols(bm, ncols, s_mid);
    send_byte(8'h0a, last);
  endtask

  task automatic expect_row(input string nm, input logic [4:0][31:0] w);
    int n;
    n = 0;
    while ((wr_cnt - rd_ptr) < 5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if ((wr_cnt - rd_ptr) < 5) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got %0d words expected 5", nm, wr_cnt - rd_ptr);
    end else begin
      for (int k = 0; k < 5; k++) chk($sformatf("%s_w%0d", nm, k), got[rd_ptr + k], w[k]);
      rd_ptr += 5;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rd_ptr = wr_cnt;
    done_seen = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    logic [159:0] ext;
    checks = 0; failures = 0; wr_cnt = 0; rd_ptr = 0; mcyc = 0;
    done_cyc = 0; done_seen = 1'b0; tog_run = 1'b0;
    rst = 1'b0; char_in = 8'h00; char_valid = 1'b0; char_last = 1'b0; ready_in = 1'b1;

    vt[0] = '{"s_row",   '0, 1'b1, mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0)};
    vt[1] = '{"edges",   {13'h1000, 32'h0, 32'h0, 32'h1, 32'h80000001}, 1'b0,
              mk(32'h80000001, 32'h00000001, 32'h0, 32'h0, 32'h00001000)};
    vt[2] = '{"ones",    '1, 1'b0,
              mk(32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff, 32'h00001fff)};
    vt[3] = '{"alt",     {13'h0aaa, 32'haaaaaaaa, 32'haaaaaaaa, 32'haaaaaaaa, 32'haaaaaaaa}, 1'b0,
              mk(32'haaaaaaaa, 32'haaaaaaaa, 32'haaaaaaaa, 32'haaaaaaaa, 32'h00000aaa)};
    vt[4] = '{"bit127",  {13'h0, 32'h80000000, 96'h0}, 1'b0,
              mk(32'h0, 32'h0, 32'h0, 32'h80000000, 32'h0)};

    // output monitor: collects handshaken words and checks hold during stalls
    fork
      begin
        logic pv, pr;
        logic [31:0] pd;
        pv = 1'b0; pr = 1'b0; pd = 32'h0;
        forever begin
          @(negedge clk);
          mcyc++;
          if (!rst) begin
            pv = 1'b0;
          end else begin
            if (pv && !pr) begin
              chk("stall_valid", {31'b0, valid_out}, 32'd1);
              chk("stall_data", data_out, pd);
            end
            if (valid_out && ready_in && wr_cnt < 2048) begin
              got[wr_cnt] = data_out;
              gcyc[wr_cnt] = mcyc;
              wr_cnt++;
            end
            if (done && !done_seen) begin
              done_seen = 1'b1;
              done_cyc = mcyc;
            end
            pv = valid_out; pr = ready_in; pd = data_out;
          end
        end
      end
    join_none

    #12;
    chk("rst_char_ready", {31'b0, char_ready}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_valid_out", {31'b0, valid_out}, 32'd0);
    chk("rst_rows_out", {24'b0, rows_out}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_ready_low", {31'b0, char_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rel_ready_high", {31'b0, char_ready}, 32'd1);

    // full file with ready_in toggling every cycle
    tog_run = 1'b1;
    fork
      begin
        while (tog_run) begin
          @(posedge clk); #1;
          ready_in = ~ready_in;
        end
      end
    join_none
    for (int r = 0; r < 142; r++) begin
      ext = {19'b0, row_bm(r)};
      for (int k = 0; k < 5; k++) expw[r * 5 + k] = ext[32 * k +: 32];
      send_row(row_bm(r), 141, (r == 0), (r == 141));
    end
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tog_run = 1'b0;
    @(posedge clk); #2;
    ready_in = 1'b1;
    chk("file_done", {31'b0, done}, 32'd1);
    chk("file_rows_out", {24'b0, rows_out}, 32'd142);
    chk("file_error", {31'b0, error}, 32'd0);
    chk("file_word_count", wr_cnt - rd_ptr, 32'd710);
    chk("file_ready_after_last", {31'b0, char_ready}, 32'd0);
    chk("file_done_latency", done_cyc, gcyc[wr_cnt - 1] + 1);
    for (int i = 0; i < 710; i++) begin
      if (rd_ptr + i < wr_cnt) chk($sformatf("file_word%0d", i), got[rd_ptr + i], expw[i]);
    end

    // table-driven rows with ready_in held high
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_row(vt[i].bm, 141, vt[i].s, 1'b0);
      expect_row(vt[i].name, vt[i].w);
    end
    chk("tbl_rows_out", {24'b0, rows_out}, 32'd5);
    chk("tbl_error", {31'b0, error}, 32'd0);

    // two rows arrive during a long downstream stall
    ready_in = 1'b0;
    base = wr_cnt;
    send_row(vt[2].bm, 141, 1'b0, 1'b0);
    send_cols(vt[3].bm, 141, 1'b0);
    char_in = 8'h0a; char_valid = 1'b1; char_last = 1'b0;
    repeat (400) @(negedge clk);
    chk("bp_ready_low", {31'b0, char_ready}, 32'd0);
    chk("bp_valid_held", {31'b0, valid_out}, 32'd1);
    chk("bp_data_held", data_out, 32'hffffffff);
    chk("bp_no_words", wr_cnt - base, 32'd0);
    @(posedge clk); #1;
    ready_in = 1'b1;
    n = 0;
    @(negedge clk);
    while (!char_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("bp_ready_rise_cycles", n, 32'd4);
    @(posedge clk); #1;
    char_valid = 1'b0;
    expect_row("bp_row1", vt[2].w);
    expect_row("bp_row2", vt[3].w);
    chk("bp_back_to_back", gcyc[base + 5], gcyc[base + 4] + 1);
    chk("bp_rows_out", {24'b0, rows_out}, 32'd7);

    // short row then over-long row
    do_reset();
    chk("err_clear", {31'b0, error}, 32'd0);
    send_row('1, 140, 1'b0, 1'b0);
    expect_row("short", mk(32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff, 32'h00000fff));
    chk("short_error", {31'b0, error}, 32'd1);
    send_row('0, 142, 1'b0, 1'b0);
    expect_row("long", mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0));
    chk("long_error", {31'b0, error}, 32'd1);

    // asynchronous reset in the middle of a row emission
    send_row(vt[1].bm, 141, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    ready_in = 1'b0;
    chk("mid_idx2_data", data_out, 32'h0);
    chk("mid_words_sent", wr_cnt - rd_ptr, 32'd2);
    chk("mid_rows_before", {24'b0, rows_out}, 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, valid_out}, 32'd0);
    chk("mid_rst_rows", {24'b0, rows_out}, 32'd0);
    chk("mid_rst_error", {31'b0, error}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rd_ptr = wr_cnt;
    ready_in = 1'b1;
    send_row(vt[1].bm, 141, 1'b0, 1'b0);
    expect_row("after_rst", vt[1].w);
    chk("after_rst_rows", {24'b0, rows_out}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
